// File: rtl/spi_sram_responder.sv
// Quad-SPI SRAM responder: decodes the EQIO/RSTIO/WRITE/READ subset from an
// oversampled SPI bus and stores data in an internal byte array with a backdoor read port.
module spi_sram_responder #(
  parameter int unsigned MEM_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      sram_cs_n,
  input  logic                      sram_sck,
  input  logic                      sram_sio0_i,
  input  logic                      sram_sio1_i,
  input  logic                      sram_sio2_i,
  input  logic                      sram_sio3_i,
  output logic                      sram_sio0_o,
  output logic                      sram_sio1_o,
  output logic                      sram_sio2_o,
  output logic                      sram_sio3_o,
  output logic                      sram_sio_oe,
  output logic                      quad_mode,
  output logic                      busy,
  input  logic [MEM_ADDR_WIDTH-1:0] dbg_addr,
  output logic [7:0]                dbg_data
);

  localparam int unsigned AW    = MEM_ADDR_WIDTH;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CNT_W = 3;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_EQIO  = 8'h38;
  localparam logic [7:0] CMD_RSTIO = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_WDATA,
    S_RDATA,
    S_IGNORE
  } state_t;

  // Two-flop synchronisers plus one extra SCK stage for edge detection
  logic       cs_m, cs_s;
  logic       sck_m, sck_s, sck_d;
  logic [3:0] sio_m, sio_s;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cs_m  <= 1'b1;
      cs_s  <= 1'b1;
      sck_m <= 1'b0;
      sck_s <= 1'b0;
      sck_d <= 1'b0;
      sio_m <= 4'h0;
      sio_s <= 4'h0;
    end else begin
      cs_m  <= sram_cs_n;
      cs_s  <= cs_m;
      sck_m <= sram_sck;
      sck_s <= sck_m;
      sck_d <= sck_s;
      sio_m <= {sram_sio3_i, sram_sio2_i, sram_sio1_i, sram_sio0_i};
      sio_s <= sio_m;
    end
  end

  logic sck_rise_c, sck_fall_c;
  assign sck_rise_c = sck_s & ~sck_d;
  assign sck_fall_c = ~sck_s & sck_d;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic [AW-1:0]      ptr_q, ptr_d;
  logic               is_write_q, is_write_d;
  logic               nib_hi_q, nib_hi_d;
  logic [3:0]         hold_q, hold_d;
  logic               quad_pend_q, quad_pend_d;
  logic               quad_val_q, quad_val_d;
  logic               quad_mode_d;
  logic               busy_d;
  logic               oe_d;
  logic [3:0]         sio_o_q, sio_o_d;
  logic               wr_en_q, wr_en_d;
  logic [AW-1:0]      wr_addr_q, wr_addr_d;
  logic [7:0]         wr_data_q, wr_data_d;

  logic [7:0] mem [DEPTH];
  logic [7:0] rd_byte_c;
  logic [7:0] sh_bits_c;
  logic       cmd_done_c;

  assign rd_byte_c  = mem[ptr_q];
  assign sh_bits_c  = quad_mode ? {shift_q[3:0], sio_s} : {shift_q[6:0], sio_s[0]};
  assign cmd_done_c = quad_mode ? (cnt_q == CNT_W'(1)) : (cnt_q == CNT_W'(7));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      is_write_q  <= 1'b0;
      nib_hi_q    <= 1'b0;
      hold_q      <= '0;
      quad_pend_q <= 1'b0;
      quad_val_q  <= 1'b0;
      quad_mode   <= 1'b0;
      busy        <= 1'b0;
      sram_sio_oe <= 1'b0;
      sio_o_q     <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      is_write_q  <= is_write_d;
      nib_hi_q    <= nib_hi_d;
      hold_q      <= hold_d;
      quad_pend_q <= quad_pend_d;
      quad_val_q  <= quad_val_d;
      quad_mode   <= quad_mode_d;
      busy        <= busy_d;
      sram_sio_oe <= oe_d;
      sio_o_q     <= sio_o_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Next-state and datapath updates; CS high overrides everything
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    is_write_d  = is_write_q;
    nib_hi_d    = nib_hi_q;
    hold_d      = hold_q;
    quad_pend_d = quad_pend_q;
    quad_val_d  = quad_val_q;
    quad_mode_d = quad_mode;
    busy_d      = ~cs_s;
    sio_o_d     = sio_o_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    if (cs_s) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      nib_hi_d    = 1'b0;
      quad_pend_d = 1'b0;
      if (quad_pend_q) quad_mode_d = quad_val_q;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d  = S_CMD;
          cnt_d    = '0;
          nib_hi_d = 1'b0;
        end
        S_CMD: if (sck_rise_c) begin
          shift_d = sh_bits_c;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cmd_done_c) begin
            cnt_d   = '0;
            state_d = S_IGNORE;
            if (!quad_mode) begin
              if (sh_bits_c == CMD_EQIO) begin
                quad_pend_d = 1'b1;
                quad_val_d  = 1'b1;
              end
            end else begin
              case (sh_bits_c)
                CMD_WRITE: begin
                  state_d    = S_ADDR;
                  is_write_d = 1'b1;
                end
                CMD_READ: begin
                  state_d    = S_ADDR;
                  is_write_d = 1'b0;
                end
                CMD_RSTIO: begin
                  quad_pend_d = 1'b1;
                  quad_val_d  = 1'b0;
                end
                default: ;
              endcase
            end
          end
        end
        S_ADDR: if (sck_rise_c) begin
          // Shifting straight into the pointer drops address bits above AW
          ptr_d = AW'({ptr_q, sio_s});
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(5)) begin
            cnt_d   = '0;
            state_d = is_write_q ? S_WDATA : S_DUMMY;
          end
        end
        S_DUMMY: if (sck_rise_c) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            cnt_d    = '0;
            nib_hi_d = 1'b0;
            state_d  = S_RDATA;
          end
        end
        S_WDATA: if (sck_rise_c) begin
          if (!nib_hi_q) begin
            hold_d   = sio_s;
            nib_hi_d = 1'b1;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = {hold_q, sio_s};
            ptr_d     = ptr_q + AW'(1);
            nib_hi_d  = 1'b0;
          end
        end
        S_RDATA: if (sck_fall_c) begin
          if (!nib_hi_q) begin
            sio_o_d  = rd_byte_c[7:4];
            nib_hi_d = 1'b1;
          end else begin
            sio_o_d  = rd_byte_c[3:0];
            nib_hi_d = 1'b0;
            ptr_d    = ptr_q + AW'(1);
          end
        end
        S_IGNORE: ;
        default: state_d = S_IDLE;
      endcase
    end

    oe_d = (state_d == S_RDATA) && !cs_s;
  end

  // Byte array: committed write one clk after the completing nibble
  always_ff @(posedge clk) begin
    if (wr_en_q) mem[wr_addr_q] <= wr_data_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) dbg_data <= 8'h00;
    else          dbg_data <= mem[dbg_addr];
  end

  assign {sram_sio3_o, sram_sio2_o, sram_sio1_o, sram_sio0_o} = sio_o_q;

endmodule

// File: tb/tb_spi_sram_responder.sv
// Bench for spi_sram_responder: host-side SPI/SQI driver with a byte-array
// reference model of memory and mode.
module tb_spi_sram_responder;

  localparam int unsigned AW   = 8;
  localparam int unsigned HALF = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          sram_cs_n;
  logic          sram_sck;
  logic          sram_sio0_i, sram_sio1_i, sram_sio2_i, sram_sio3_i;
  logic          sram_sio0_o, sram_sio1_o, sram_sio2_o, sram_sio3_o;
  logic          sram_sio_oe;
  logic          quad_mode;
  logic          busy;
  logic [AW-1:0] dbg_addr;
  logic [7:0]    dbg_data;

  always #5 clk = ~clk;

  spi_sram_responder #(.MEM_ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sram_cs_n   (sram_cs_n),
    .sram_sck    (sram_sck),
    .sram_sio0_i (sram_sio0_i),
    .sram_sio1_i (sram_sio1_i),
    .sram_sio2_i (sram_sio2_i),
    .sram_sio3_i (sram_sio3_i),
    .sram_sio0_o (sram_sio0_o),
    .sram_sio1_o (sram_sio1_o),
    .sram_sio2_o (sram_sio2_o),
    .sram_sio3_o (sram_sio3_o),
    .sram_sio_oe (sram_sio_oe),
    .quad_mode   (quad_mode),
    .busy        (busy),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  logic [7:0] model_mem [256];
  logic       model_quad;
  logic [7:0] wq [$];
  int         ntests = 0;
  int         nfail  = 0;

  // One SCK period: drive nibble while low, sample DUT outputs at the rising edge
  task automatic clk_nib(input logic [3:0] o, output logic [3:0] i, output logic oe_s);
    @(negedge clk);
    {sram_sio3_i, sram_sio2_i, sram_sio1_i, sram_sio0_i} = o;
    repeat (HALF - 1) @(negedge clk);
    sram_sck = 1'b1;
    i    = {sram_sio3_o, sram_sio2_o, sram_sio1_o, sram_sio0_o};
    oe_s = sram_sio_oe;
    repeat (HALF) @(negedge clk);
    sram_sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic quad, inout logic any_oe);
    logic [3:0] rx;
    logic       oe_s;
    if (quad) begin
      clk_nib(b[7:4], rx, oe_s); any_oe |= oe_s;
      clk_nib(b[3:0], rx, oe_s); any_oe |= oe_s;
    end else begin
      for (int k = 7; k >= 0; k--) begin
        clk_nib({3'b000, b[k]}, rx, oe_s);
        any_oe |= oe_s;
      end
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    sram_cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    @(negedge clk);
    sram_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic peek(input logic [AW-1:0] a, output logic [7:0] d);
    @(negedge clk);
    dbg_addr = a;
    @(negedge clk);
    d = dbg_data;
  endtask

  task automatic eqio();
    logic o = 1'b0;
    cs_low();
    send_byte(8'h38, 1'b0, o);
    cs_high();
    model_quad = 1'b1;
  endtask

  // SQI write of the bytes queued in wq; model updated by address arithmetic
  task automatic sqi_write(input logic [23:0] a);
    logic o = 1'b0;
    cs_low();
    send_byte(8'h02, 1'b1, o);
    send_byte(a[23:16], 1'b1, o);
    send_byte(a[15:8], 1'b1, o);
    send_byte(a[7:0], 1'b1, o);
    foreach (wq[k]) begin
      send_byte(wq[k], 1'b1, o);
      model_mem[8'(a[7:0] + k)] = wq[k];
    end
    cs_high();
  endtask

  task automatic sqi_read(input logic [23:0] a, input int n, input string name);
    logic       o = 1'b0;
    logic [3:0] nh, nl;
    logic       oeh, oel;
    logic [7:0] exp_b;
    cs_low();
    send_byte(8'h03, 1'b1, o);
    send_byte(a[23:16], 1'b1, o);
    send_byte(a[15:8], 1'b1, o);
    send_byte(a[7:0], 1'b1, o);
    send_byte(8'h00, 1'b1, o);
    ntests++;
    if (o !== 1'b0) begin
      nfail++;
      $display("FAIL %s_oe_pre: oe seen %b before data, expected 0", name, o);
    end
    for (int k = 0; k < n; k++) begin
      exp_b = model_mem[8'(a[7:0] + k)];
      clk_nib(4'h0, nh, oeh);
      clk_nib(4'h0, nl, oel);
      ntests++;
      if ({nh, nl} !== exp_b) begin
        nfail++;
        $display("FAIL %s_data[%0d]: got %h expected %h", name, k, {nh, nl}, exp_b);
      end
      ntests++;
      if ({oeh, oel} !== 2'b11) begin
        nfail++;
        $display("FAIL %s_oe_data[%0d]: got %b expected 11", name, k, {oeh, oel});
      end
    end
    @(negedge clk);
    sram_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    ntests++;
    if (sram_sio_oe !== 1'b0) begin
      nfail++;
      $display("FAIL %s_oe_drop: got %b expected 0", name, sram_sio_oe);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    ntests++;
    if (sram_sio_oe !== 1'b0) begin nfail++; $display("FAIL reset_oe: got %b expected 0", sram_sio_oe); end
    ntests++;
    if (quad_mode !== 1'b0) begin nfail++; $display("FAIL reset_quad: got %b expected 0", quad_mode); end
    ntests++;
    if (busy !== 1'b0) begin nfail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    ntests++;
    if ({sram_sio3_o, sram_sio2_o, sram_sio1_o, sram_sio0_o} !== 4'h0) begin
      nfail++;
      $display("FAIL reset_sio: got %h expected 0", {sram_sio3_o, sram_sio2_o, sram_sio1_o, sram_sio0_o});
    end
    ntests++;
    if (dbg_data !== 8'h00) begin nfail++; $display("FAIL reset_dbg: got %h expected 00", dbg_data); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    model_quad = 1'b0;
  endtask

  task automatic test_enter_sqi();
    logic o = 1'b0;
    cs_low();
    ntests++;
    if (busy !== 1'b1) begin nfail++; $display("FAIL eqio_busy: got %b expected 1", busy); end
    send_byte(8'h38, 1'b0, o);
    cs_high();
    model_quad = 1'b1;
    ntests++;
    if (quad_mode !== model_quad) begin nfail++; $display("FAIL eqio_quad: got %b expected %b", quad_mode, model_quad); end
    ntests++;
    if (busy !== 1'b0) begin nfail++; $display("FAIL eqio_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_sqi_write();
    logic [7:0] d;
    wq = '{8'hAB, 8'hCD};
    sqi_write(24'h000010);
    peek(8'h10, d);
    ntests++;
    if (d !== model_mem[8'h10]) begin nfail++; $display("FAIL write_0x10: got %h expected %h", d, model_mem[8'h10]); end
    peek(8'h11, d);
    ntests++;
    if (d !== model_mem[8'h11]) begin nfail++; $display("FAIL write_0x11: got %h expected %h", d, model_mem[8'h11]); end
  endtask

  // SPI-format WRITE sent while in SQI mode decodes as an unknown command
  task automatic test_ignore();
    logic       o = 1'b0;
    logic [7:0] d;
    cs_low();
    send_byte(8'h02, 1'b0, o);
    send_byte(8'h00, 1'b0, o);
    send_byte(8'h00, 1'b0, o);
    send_byte(8'h10, 1'b0, o);
    send_byte(8'h55, 1'b0, o);
    cs_high();
    ntests++;
    if (quad_mode !== model_quad) begin nfail++; $display("FAIL ignore_quad: got %b expected %b", quad_mode, model_quad); end
    peek(8'h10, d);
    ntests++;
    if (d !== model_mem[8'h10]) begin nfail++; $display("FAIL ignore_0x10: got %h expected %h", d, model_mem[8'h10]); end
    peek(8'h11, d);
    ntests++;
    if (d !== model_mem[8'h11]) begin nfail++; $display("FAIL ignore_0x11: got %h expected %h", d, model_mem[8'h11]); end
  endtask

  task automatic test_sqi_read();
    sqi_read(24'h000010, 2, "read");
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    wq = '{8'h11, 8'h22};
    sqi_write(24'h0000FF);
    peek(8'hFF, d);
    ntests++;
    if (d !== 8'h11) begin nfail++; $display("FAIL wrap_0xff: got %h expected 11", d); end
    peek(8'h00, d);
    ntests++;
    if (d !== 8'h22) begin nfail++; $display("FAIL wrap_0x00: got %h expected 22", d); end
    sqi_read(24'h0000FF, 2, "wrap_read");
  endtask

  task automatic test_abort();
    logic       o = 1'b0;
    logic [3:0] rx;
    logic       oe_s;
    logic [7:0] d;
    wq = '{8'h00, 8'h99};
    sqi_write(24'h000020);
    cs_low();
    send_byte(8'h02, 1'b1, o);
    send_byte(8'h00, 1'b1, o);
    send_byte(8'h00, 1'b1, o);
    send_byte(8'h20, 1'b1, o);
    clk_nib(4'h5, rx, oe_s);
    clk_nib(4'hA, rx, oe_s);
    clk_nib(4'h7, rx, oe_s);
    cs_high();
    model_mem[8'h20] = 8'h5A;
    peek(8'h20, d);
    ntests++;
    if (d !== model_mem[8'h20]) begin nfail++; $display("FAIL abort_0x20: got %h expected %h", d, model_mem[8'h20]); end
    peek(8'h21, d);
    ntests++;
    if (d !== model_mem[8'h21]) begin nfail++; $display("FAIL abort_0x21: got %h expected %h", d, model_mem[8'h21]); end
    cs_low();
    send_byte(8'hFF, 1'b1, o);
    cs_high();
    model_quad = 1'b0;
    ntests++;
    if (quad_mode !== model_quad) begin nfail++; $display("FAIL rstio_quad: got %b expected %b", quad_mode, model_quad); end
  endtask

  task automatic test_reset_mid();
    logic o = 1'b0;
    eqio();
    ntests++;
    if (quad_mode !== 1'b1) begin nfail++; $display("FAIL mid_pre_quad: got %b expected 1", quad_mode); end
    cs_low();
    send_byte(8'h02, 1'b1, o);
    send_byte(8'h00, 1'b1, o);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    model_quad = 1'b0;
    ntests++;
    if (quad_mode !== model_quad) begin nfail++; $display("FAIL mid_quad: got %b expected 0", quad_mode); end
    ntests++;
    if (busy !== 1'b0) begin nfail++; $display("FAIL mid_busy: got %b expected 0", busy); end
    reset_n = 1'b1;
    cs_high();
    ntests++;
    if (quad_mode !== model_quad) begin nfail++; $display("FAIL mid_post_quad: got %b expected 0", quad_mode); end
  endtask

  task automatic test_random();
    logic [23:0] addrs [6];
    int          lens  [6];
    logic [7:0]  d;
    eqio();
    for (int k = 0; k < 6; k++) begin
      addrs[k] = 24'($urandom);
      lens[k]  = int'($urandom_range(1, 4));
      wq.delete();
      for (int j = 0; j < lens[k]; j++) wq.push_back(8'($urandom));
      sqi_write(addrs[k]);
    end
    for (int k = 0; k < 6; k++) begin
      peek(addrs[k][7:0], d);
      ntests++;
      if (d !== model_mem[addrs[k][7:0]]) begin
        nfail++;
        $display("FAIL rand_peek[%0d]: got %h expected %h", k, d, model_mem[addrs[k][7:0]]);
      end
      sqi_read(addrs[k], lens[k], "rand_read");
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    sram_cs_n   = 1'b1;
    sram_sck    = 1'b0;
    sram_sio0_i = 1'b0;
    sram_sio1_i = 1'b0;
    sram_sio2_i = 1'b0;
    sram_sio3_i = 1'b0;
    dbg_addr    = '0;
    model_quad  = 1'b0;

    test_reset();
    test_enter_sqi();
    test_sqi_write();
    test_ignore();
    test_sqi_read();
    test_wrap();
    test_abort();
    test_reset_mid();
    test_random();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/spi_sram_responder.md
# spi_sram_responder

Synthesizable quad-SPI SRAM responder: the slave end of the `sram_cs_n` / `sram_sck` / `sram_sio*` bus driven by `spi_sram_encoder`. It decodes the 23LC1024-style command subset the encoder issues and stores data in an internal byte array. It replaces the behavioural SRAM model in gate-level and FPGA builds of the ROM loading path, and gives benches a backdoor port for checking memory contents.

## Interface
- `MEM_ADDR_WIDTH`, 10: internal array is 2^MEM_ADDR_WIDTH bytes; only the low MEM_ADDR_WIDTH address bits are used.
- `clk` in 1: system clock; also oversamples the SPI bus.
- `reset_n` in 1: synchronous, active-low reset.
- `sram_cs_n` in 1: chip select, active low.
- `sram_sck` in 1: SPI clock, mode 0.
- `sram_sio0_i`..`sram_sio3_i` in 1 each: bus inputs.
- `sram_sio0_o`..`sram_sio3_o` out 1 each: bus outputs. `sram_sio3_o` is the nibble MSB.
- `sram_sio_oe` out 1: output enable for all four SIO lines.
- `quad_mode` out 1: 1 = SQI mode active.
- `busy` out 1: transaction in progress (synced CS low).
- `dbg_addr` in MEM_ADDR_WIDTH: backdoor read address.
- `dbg_data` out 8: byte at `dbg_addr`, registered, 1-cycle latency.

## Operation
- **Input sync.** `sram_cs_n`, `sram_sck` and `sram_sio*_i` each pass through 2 flops.
  - Rising and falling SCK edges are detected from the synced SCK.
  - All bus decoding uses the synced values only.
- **States:** IDLE, CMD, ADDR, DUMMY, WDATA, RDATA, IGNORE.
- **Abort.** Synced CS high forces IDLE from any state on the next clk, and deasserts `sram_sio_oe`.
- **IDLE → CMD** on synced CS low.
- **CMD in SPI mode (`quad_mode`=0).** Eight bits are sampled on `sio0`, MSB first, one per rising edge.
  - 0x38 (EQIO): `quad_mode` is set when synced CS rises.
  - Any other command → IGNORE.
- **CMD in SQI mode.** Two nibbles, high nibble first.
  - 0x02 (WRITE) → ADDR.
  - 0x03 (READ) → ADDR.
  - 0xFF (RSTIO): `quad_mode` is cleared when synced CS rises.
  - Any other command → IGNORE.
- **ADDR.** Six nibbles form a 24-bit address, MSB first. Bits above MEM_ADDR_WIDTH are discarded.
  - WRITE → WDATA.
  - READ → DUMMY.
- **DUMMY.** Two rising edges (one dummy byte), then → RDATA.
- **WDATA.**
  - Each pair of nibbles (high nibble first) forms a byte.
  - The byte is written to `mem[ptr]` on the clk after the second nibble.
  - `ptr` then increments, wrapping from 2^MEM_ADDR_WIDTH−1 to 0.
  - A partial byte at CS rise is discarded.
- **RDATA.**
  - `sram_sio_oe`=1 while in RDATA with synced CS low.
  - On each falling edge the output nibble advances: high nibble of `mem[ptr]`, then the low nibble, then `ptr` increments with wrap.
  - The first nibble is driven on the falling edge that follows the last dummy rising edge.
- **IGNORE.** Bus is ignored until CS rises; `sram_sio_oe`=0.
- **Memory** is a single-port array. Writes take priority; `dbg_data` is read on a separate read port. Memory contents are not reset.

## Timing
- **Reset values (`reset_n`=0 at a clk edge):**
  - state IDLE, `quad_mode`=0, `busy`=0, `sram_sio_oe`=0, `sram_sio*_o`=0, `dbg_data`=0.
  - Sync flops reset to CS=1 and SCK=0.
  - Reset mid-transaction discards the transaction and returns to SPI mode.
- **Input latency.** An SCK edge is acted on 3 clk after it occurs at the pin. Data are sampled from the same synced stage.
- **Output latency.** The read nibble reaches `sram_sio*_o` ≤3 clk after the SCK falling edge at the pin.
- **SCK constraints.**
  - SCK high ≥4 clk and SCK low ≥4 clk, so that read data is valid at the host's rising edge.
  - CS high ≥4 clk between transactions.
- **Write-then-read.** The write commit completes before any subsequent READ data phase can start.
- **Backdoor.** `dbg_data` reflects a WDATA commit one clk after the commit.

## Test plan
- **Reset:** hold `reset_n`=0 for 3 clk → `sram_sio_oe`=0, `quad_mode`=0, `busy`=0, `sram_sio*_o`=0.
- **Enter SQI:** send SPI 0x38 on `sio0`, raise CS → `quad_mode`=1. A second transaction sending SPI 0x02 in SPI mode is IGNOREd, and memory is unchanged.
- **SQI write:** 0x02, address 0x000010, data 0xAB, 0xCD → `dbg_data`=0xAB at `dbg_addr` 0x10 and 0xCD at 0x11.
- **SQI read:** 0x03, address 0x000010, 2 dummy nibbles, 4 data nibbles → host samples 0xA, 0xB, 0xC, 0xD.
  - `sram_sio_oe` is 1 only in the data phase.
  - `sram_sio_oe` drops ≤3 clk after CS rises.
- **Wrap:** MEM_ADDR_WIDTH=8, write 0x11, 0x22 at address 0x0000FF → `mem[0xFF]`=0x11, `mem[0x00]`=0x22.
  - A read from 0xFF returns 0x11, then 0x22.
- **Abort:**
  - Write at 0x20 with 3 nibbles 0x5, 0xA, 0x7, then CS high → `mem[0x20]`=0x5A and `mem[0x21]` is unchanged.
  - Then send SQI 0xFF → `quad_mode`=0.
